// File: rtl/ram_dp_arb.sv
// ram_dp_arb: shares one dual-port RAM among NUM_REQ requesters.
// Each cycle a round-robin scan picks up to two distinct requesters. The first
// winner drives port A and the second drives port B. Read data comes back one
// cycle later and is steered to the requester that issued the read.
// Optional build macro: RAM_DP_ARB_FIXED_PRIO_EN pins the scan pointer to 0,
// which gives fixed priority with index 0 highest.
// Handshake: a requester raises req_i and holds we_i/addr_i/wdata_i stable
// until it sees gnt_o high. The access is accepted on the rising edge that ends
// that cycle. Read data appears on rvalid_o/rdata_o in the next cycle, and the
// return path has no back-pressure.
module ram_dp_arb #(
  parameter int NUM_REQ    = 4,
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*Addr_Width-1:0]  addr_i,
  input  logic [NUM_REQ*Word_Width-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [NUM_REQ*Word_Width-1:0]  rdata_o,
  output logic                           cena_o,
  output logic                           wena_o,
  output logic                           oena_o,
  output logic [Addr_Width-1:0]          addra_o,
  output logic [Word_Width-1:0]          dataa_o,
  input  logic [Word_Width-1:0]          dataa_i,
  output logic                           cenb_o,
  output logic                           wenb_o,
  output logic                           oenb_o,
  output logic [Addr_Width-1:0]          addrb_o,
  output logic [Word_Width-1:0]          datab_o,
  input  logic [Word_Width-1:0]          datab_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [Addr_Width-1:0] w_addr  [NUM_REQ];
  logic [Word_Width-1:0] w_wdata [NUM_REQ];

  logic [PW-1:0] w_ptr;
  int            w_scan;
  logic [PW-1:0] w_scan_idx;
  logic          w_a_found;
  logic          w_b_found;
  logic [PW-1:0] w_a_idx;
  logic [PW-1:0] w_b_idx;
  logic          w_ww_conflict;
  logic          w_a_gnt;
  logic          w_b_gnt;

  logic          r_rda_v;
  logic [PW-1:0] r_rda_id;
  logic          r_rdb_v;
  logic [PW-1:0] r_rdb_id;

  // Unpack the flat address and write-data buses into per-requester arrays.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_addr[k]  = addr_i[k*Addr_Width +: Addr_Width];
      w_wdata[k] = wdata_i[k*Word_Width +: Word_Width];
    end
  end

  // Scan from ptr upward (wrapping): first requester found -> A, next -> B.
  always_comb begin
    w_a_found  = 1'b0;
    w_b_found  = 1'b0;
    w_a_idx    = '0;
    w_b_idx    = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan     = (int'(w_ptr) + i) % NUM_REQ;
      w_scan_idx = PW'(w_scan);
      if (req_i[w_scan_idx]) begin
        if (!w_a_found) begin
          w_a_found = 1'b1;
          w_a_idx   = w_scan_idx;
        end else if (!w_b_found) begin
          w_b_found = 1'b1;
          w_b_idx   = w_scan_idx;
        end
      end
    end
  end

  // Two writes to one address cannot both land. Port B's winner waits, and no
  // one else is promoted into port B this cycle.
  assign w_ww_conflict = w_a_found && w_b_found &&
                         we_i[w_a_idx] && we_i[w_b_idx] &&
                         (w_addr[w_a_idx] == w_addr[w_b_idx]);

  assign w_a_gnt = !rst && w_a_found;
  assign w_b_gnt = !rst && w_b_found && !w_ww_conflict;

  // One-hot grant vector built from the two port winners.
  always_comb begin
    gnt_o = '0;
    if (w_a_gnt) gnt_o[w_a_idx] = 1'b1;
    if (w_b_gnt) gnt_o[w_b_idx] = 1'b1;
  end

  // Port A drive: mux the winner's request onto the port, or idle it.
  always_comb begin
    cena_o  = 1'b1;
    wena_o  = 1'b1;
    addra_o = '0;
    dataa_o = '0;
    if (w_a_gnt) begin
      cena_o  = 1'b0;
      wena_o  = !we_i[w_a_idx];
      addra_o = w_addr[w_a_idx];
      dataa_o = w_wdata[w_a_idx];
    end
  end

  // Port B drive: mux the winner's request onto the port, or idle it.
  always_comb begin
    cenb_o  = 1'b1;
    wenb_o  = 1'b1;
    addrb_o = '0;
    datab_o = '0;
    if (w_b_gnt) begin
      cenb_o  = 1'b0;
      wenb_o  = !we_i[w_b_idx];
      addrb_o = w_addr[w_b_idx];
      datab_o = w_wdata[w_b_idx];
    end
  end

`ifdef RAM_DP_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_last;
  logic [PW-1:0] w_next_ptr;

  // The pointer moves just past the last index granted (B if granted, else A).
  always_comb begin
    w_last     = w_b_gnt ? w_b_idx : w_a_idx;
    w_next_ptr = PW'((int'(w_last) + 1) % NUM_REQ);
  end

  // Round-robin pointer: holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_a_gnt) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Remember which requester owns each port's read data next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rda_v  <= 1'b0;
      r_rda_id <= '0;
      r_rdb_v  <= 1'b0;
      r_rdb_id <= '0;
    end else begin
      r_rda_v  <= w_a_gnt && !we_i[w_a_idx];
      r_rda_id <= w_a_idx;
      r_rdb_v  <= w_b_gnt && !we_i[w_b_idx];
      r_rdb_id <= w_b_idx;
    end
  end

  assign oena_o = !r_rda_v;
  assign oenb_o = !r_rdb_v;

  // Steer returning read data to its owner. Every other slice reads zero.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_rda_v && (r_rda_id == PW'(k))) begin
        rvalid_o[k]                          = 1'b1;
        rdata_o[k*Word_Width +: Word_Width]  = dataa_i;
      end
      if (r_rdb_v && (r_rdb_id == PW'(k))) begin
        rvalid_o[k]                          = 1'b1;
        rdata_o[k*Word_Width +: Word_Width]  = datab_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_arb.sv
// Testbench for ram_dp_arb.
// A behavioural RAM stands in for ram_dp. A reference model derives grants,
// port drive and read returns from the arbitration rules using a queue of
// requesters in scan order and a shadow memory.
module tb_ram_dp_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int NW = N * W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N-1:0]    we_i;
  logic [N*AW-1:0] addr_i;
  logic [NW-1:0]   wdata_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rvalid_o;
  logic [NW-1:0]   rdata_o;
  logic            cena_o, wena_o, oena_o, cenb_o, wenb_o, oenb_o;
  logic [AW-1:0]   addra_o, addrb_o;
  logic [W-1:0]    dataa_o, datab_o, dataa_i, datab_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  ram_dp_arb #(.NUM_REQ(N), .Word_Width(W), .Addr_Width(AW)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .cena_o(cena_o), .wena_o(wena_o), .oena_o(oena_o),
    .addra_o(addra_o), .dataa_o(dataa_o), .dataa_i(dataa_i),
    .cenb_o(cenb_o), .wenb_o(wenb_o), .oenb_o(oenb_o),
    .addrb_o(addrb_o), .datab_o(datab_o), .datab_i(datab_i)
  );

  // Behavioural dual-port RAM: registered read, output gated by oen.
  logic [W-1:0] ram [256];
  logic [W-1:0] qa = '0;
  logic [W-1:0] qb = '0;
  always @(posedge clk) begin
    if (!cena_o) begin
      if (!wena_o) ram[addra_o] <= dataa_o;
      else         qa <= ram[addra_o];
    end
    if (!cenb_o) begin
      if (!wenb_o) ram[addrb_o] <= datab_o;
      else         qb <= ram[addrb_o];
    end
  end
  assign dataa_i = oena_o ? '0 : qa;
  assign datab_i = oenb_o ? '0 : qb;

  // Scoreboard state
  logic [W-1:0]    m_mem [256];
  int              m_ptr = 0;
  logic [NW-1:0]   exp_q[$];
  logic [N+1:0]    exp_ctl_q[$];

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] req_addr(input int k);
    return addr_i[k*AW +: AW];
  endfunction

  function automatic logic [W-1:0] req_data(input int k);
    return wdata_i[k*W +: W];
  endfunction

  // One cycle of the reference model: check last cycle's reads, then this cycle's grants.
  task automatic model_cycle();
    int            order[$];
    int            a, b;
    logic          ga, gb;
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [NW-1:0] erd;
    logic          eoa, eob;
    if (exp_q.size() > 0) begin
      erd = exp_q.pop_front();
      {erv, eoa, eob} = exp_ctl_q.pop_front();
    end else begin
      erd = '0; erv = '0; eoa = 1'b1; eob = 1'b1;
    end
    chk("rvalid", rvalid_o, erv);
    chk("rdata", rdata_o, erd);
    chk("oena", oena_o, eoa);
    chk("oenb", oenb_o, eob);

    for (int i = 0; i < N; i++) begin
      if (req_i[(m_ptr + i) % N]) order.push_back((m_ptr + i) % N);
    end
    ga = (order.size() > 0);
    gb = (order.size() > 1);
    a  = ga ? order[0] : 0;
    b  = gb ? order[1] : 0;
    if (ga && gb && we_i[a] && we_i[b] && (req_addr(a) == req_addr(b))) gb = 1'b0;
    eg = '0;
    if (ga) eg[a] = 1'b1;
    if (gb) eg[b] = 1'b1;
    chk("gnt", gnt_o, eg);
    chk("cena", cena_o, !ga);
    chk("wena", wena_o, ga ? !we_i[a] : 1'b1);
    chk("addra", addra_o, ga ? req_addr(a) : '0);
    chk("dataa", dataa_o, ga ? req_data(a) : '0);
    chk("cenb", cenb_o, !gb);
    chk("wenb", wenb_o, gb ? !we_i[b] : 1'b1);
    chk("addrb", addrb_o, gb ? req_addr(b) : '0);
    chk("datab", datab_o, gb ? req_data(b) : '0);

    erd = '0; erv = '0; eoa = 1'b1; eob = 1'b1;
    if (ga && !we_i[a]) begin erv[a] = 1'b1; erd[a*W +: W] = m_mem[req_addr(a)]; eoa = 1'b0; end
    if (gb && !we_i[b]) begin erv[b] = 1'b1; erd[b*W +: W] = m_mem[req_addr(b)]; eob = 1'b0; end
    if (ga && we_i[a]) m_mem[req_addr(a)] = req_data(a);
    if (gb && we_i[b]) m_mem[req_addr(b)] = req_data(b);
    exp_q.push_back(erd);
    exp_ctl_q.push_back({erv, eoa, eob});
`ifndef RAM_DP_ARB_FIXED_PRIO_EN
    if (ga) m_ptr = ((gb ? b : a) + 1) % N;
`endif
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", gnt_o, '0);
        chk("rst_rvalid", rvalid_o, '0);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_ctl", {cena_o, cenb_o, wena_o, wenb_o, oena_o, oenb_o}, 6'h3f);
        m_ptr = 0;
        exp_q.delete();
        exp_ctl_q.delete();
      end else begin
        model_cycle();
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    we_i[k]              = w;
    addr_i[k*AW +: AW]   = a;
    wdata_i[k*W +: W]    = d;
  endtask

  task automatic do_reset();
    req_i = '0;
    rst   = 1'b1;
    step();
    step();
    rst   = 1'b0;
  endtask

  initial begin : main
    logic [N-1:0] g;
    logic [N-1:0] act;
    logic [W-1:0] v;
    int           cnt [N];
    rst = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram[i]  <= v;
      m_mem[i] = v;
    end
    ram[8'h10]  <= 32'hA5A5_0001;
    m_mem[8'h10] = 32'hA5A5_0001;
    step();
    step();

    // Single read after reset
    rst = 1'b0;
    set_req(0, 1'b0, 8'h10, '0);
    req_i = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", gnt_o, 4'b0001);
    chk("t1_cena", cena_o, 1'b0);
    chk("t1_wena", wena_o, 1'b1);
    step();
    req_i = '0;
    @(negedge clk);
    chk("t1_rvalid", rvalid_o, 4'b0001);
    chk("t1_rdata", rdata_o[W-1:0], 32'hA5A5_0001);
    chk("t1_oena", oena_o, 1'b0);

    // Dual write then read back
    do_reset();
    set_req(0, 1'b1, 8'h01, 32'h1111_1111);
    set_req(1, 1'b1, 8'h02, 32'h2222_2222);
    req_i = 4'b0011;
    @(negedge clk);
    chk("t2_gnt", gnt_o, 4'b0011);
    chk("t2_addra", addra_o, 8'h01);
    chk("t2_addrb", addrb_o, 8'h02);
    step();
    set_req(0, 1'b0, 8'h01, '0);
    set_req(1, 1'b0, 8'h02, '0);
    step();
    req_i = '0;
    @(negedge clk);
    chk("t2_rvalid", rvalid_o, 4'b0011);
    chk("t2_rdata0", rdata_o[W-1:0], 32'h1111_1111);
    chk("t2_rdata1", rdata_o[W +: W], 32'h2222_2222);

    // Write-write conflict on one address
    do_reset();
    set_req(0, 1'b1, 8'h20, 32'hAAAA_0000);
    set_req(2, 1'b1, 8'h20, 32'hBBBB_2222);
    req_i = 4'b0101;
    @(negedge clk);
    chk("t3_gnt0", gnt_o, 4'b0001);
    chk("t3_cenb", cenb_o, 1'b1);
    step();
    req_i = 4'b0100;
    @(negedge clk);
    chk("t3_gnt1", gnt_o, 4'b0100);
    step();
    set_req(1, 1'b0, 8'h20, '0);
    req_i = 4'b0010;
    step();
    req_i = '0;
    @(negedge clk);
    chk("t3_rvalid", rvalid_o, 4'b0010);
    chk("t3_final", rdata_o[W +: W], 32'hBBBB_2222);

    // Reset asserted in the grant cycle of a read
    do_reset();
    set_req(0, 1'b0, 8'h10, '0);
    req_i = 4'b0001;
    @(negedge clk);
    chk("t4_gnt", gnt_o, 4'b0001);
    #1 rst = 1'b1;
    step();
    req_i = '0;
    @(negedge clk);
    chk("t4_rvalid", rvalid_o, '0);
    chk("t4_ctl", {cena_o, cenb_o, wena_o, wenb_o, oena_o, oenb_o}, 6'h3f);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rvalid_after", rvalid_o, '0);

    // All four requesters hold reads continuously
    do_reset();
    for (int k = 0; k < N; k++) begin
      set_req(k, 1'b0, AW'($urandom_range(0, 255)), '0);
      cnt[k] = 0;
    end
    req_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
`ifdef RAM_DP_ARB_FIXED_PRIO_EN
      chk("t5_fixed_gnt", gnt_o, 4'b0011);
`else
      chk("t5_rr_gnt", gnt_o, (c % 2 == 0) ? 4'b0011 : 4'b1100);
`endif
      for (int k = 0; k < N; k++) cnt[k] += int'(rvalid_o[k]);
      step();
    end
    req_i = '0;
`ifdef RAM_DP_ARB_FIXED_PRIO_EN
    chk("t5_cnt0", cnt[0], 7);
    chk("t5_cnt2", cnt[2], 0);
    chk("t5_cnt3", cnt[3], 0);
`else
    chk("t5_cnt0", cnt[0], 4);
    chk("t5_cnt1", cnt[1], 4);
    chk("t5_cnt2", cnt[2], 3);
    chk("t5_cnt3", cnt[3], 3);
`endif

    // Randomized traffic on a small address window to provoke conflicts
    act = '0;
    step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt_o;
      step();
      for (int k = 0; k < N; k++) begin
        if (act[k] && g[k]) act[k] = 1'b0;
        if (!act[k] && ($urandom_range(0, 3) != 0)) begin
          act[k] = 1'b1;
          set_req(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
      end
      req_i = act;
    end
    req_i = '0;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
